// File: rtl/arc_alu_pkg.sv
// Shared encodings for the ARC EX-stage ALU control decoder and the
// iterative multiply/divide sequencer.
package arc_alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND     = 4'd0,
        ALU_OR      = 4'd1,
        ALU_ADD     = 4'd2,
        ALU_SLL     = 4'd3,
        ALU_SRL     = 4'd4,
        ALU_BNE     = 4'd5,
        ALU_SUB     = 4'd6,
        ALU_SLT     = 4'd7,
        ALU_LUI     = 4'd8,
        ALU_SRA     = 4'd9,
        ALU_SLTU    = 4'd10,
        ALU_HILO    = 4'd11,
        ALU_NOR     = 4'd12,
        ALU_XOR     = 4'd13,
        ALU_JR      = 4'd14,
        ALU_INVALID = 4'd15
    } alu_ctrl_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'd0;
    localparam logic [5:0] FUNCT_SRL   = 6'd2;
    localparam logic [5:0] FUNCT_SRA   = 6'd3;
    localparam logic [5:0] FUNCT_JR    = 6'd8;
    localparam logic [5:0] FUNCT_JALR  = 6'd9;
    localparam logic [5:0] FUNCT_MFHI  = 6'd16;
    localparam logic [5:0] FUNCT_MTHI  = 6'd17;
    localparam logic [5:0] FUNCT_MFLO  = 6'd18;
    localparam logic [5:0] FUNCT_MTLO  = 6'd19;
    localparam logic [5:0] FUNCT_MULT  = 6'd24;
    localparam logic [5:0] FUNCT_MULTU = 6'd25;
    localparam logic [5:0] FUNCT_DIV   = 6'd26;
    localparam logic [5:0] FUNCT_DIVU  = 6'd27;
    localparam logic [5:0] FUNCT_ADD   = 6'd32;
    localparam logic [5:0] FUNCT_ADDU  = 6'd33;
    localparam logic [5:0] FUNCT_SUB   = 6'd34;
    localparam logic [5:0] FUNCT_SUBU  = 6'd35;
    localparam logic [5:0] FUNCT_AND   = 6'd36;
    localparam logic [5:0] FUNCT_OR    = 6'd37;
    localparam logic [5:0] FUNCT_XOR   = 6'd38;
    localparam logic [5:0] FUNCT_NOR   = 6'd39;
    localparam logic [5:0] FUNCT_SLT   = 6'd42;
    localparam logic [5:0] FUNCT_SLTU  = 6'd43;

    localparam logic [3:0] OTHER_ADDI  = 4'd0;
    localparam logic [3:0] OTHER_ANDI  = 4'd1;
    localparam logic [3:0] OTHER_ORI   = 4'd2;
    localparam logic [3:0] OTHER_XORI  = 4'd3;
    localparam logic [3:0] OTHER_LUI   = 4'd4;
    localparam logic [3:0] OTHER_BNE   = 4'd5;
    localparam logic [3:0] OTHER_SLTI  = 4'd6;
    localparam logic [3:0] OTHER_SLTIU = 4'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_core.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) datapath on
// operand magnitudes, with a final two's-complement sign correction in FIX.
module muldiv_core
    import arc_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic              i_is_div,
    input  logic              i_is_signed,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_divzero,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    md_state_e         state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              dz_q, dz_d;

    logic              rs_neg, rt_neg, start_dz, last_step;
    logic [DATA_W-1:0] rs_mag, rt_mag;
    logic [DATA_W:0]   mul_sum, div_shift;
    logic [DATA_W-1:0] div_diff;
    logic              div_ge;
    logic [2*DATA_W-1:0] prod_fix;

    assign rs_neg    = i_is_signed & i_rs[DATA_W-1];
    assign rt_neg    = i_is_signed & i_rt[DATA_W-1];
    assign rs_mag    = rs_neg ? -i_rs : i_rs;
    assign rt_mag    = rt_neg ? -i_rt : i_rt;
    assign start_dz  = i_is_div && (i_rt == '0);
    assign last_step = (cnt_q == CNT_W'(DATA_W - 1));

    // {acc,quo} is the running product for multiply and {remainder,dividend/quotient} for divide.
    assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {acc_q, quo_q[DATA_W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_diff  = div_shift[DATA_W-1:0] - opb_q;
    assign prod_fix  = neg_lo_q ? -{acc_q, quo_q} : {acc_q, quo_q};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MD_IDLE: if (i_start) state_d = start_dz ? MD_FIX : MD_RUN;
            MD_RUN: begin
                if (i_flush)        state_d = MD_IDLE;
                else if (last_step) state_d = MD_FIX;
            end
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (state_q != MD_IDLE);
        o_done    = (state_q == MD_FIX) && !i_flush;
        o_divzero = (state_q == MD_FIX) && !i_flush && dz_q;
        if (is_div_q) begin
            o_hi = neg_hi_q ? -acc_q : acc_q;
            o_lo = neg_lo_q ? -quo_q : quo_q;
        end else begin
            {o_hi, o_lo} = prod_fix;
        end
    end

    always_comb begin
        acc_d    = acc_q;
        quo_d    = quo_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        unique case (state_q)
            MD_IDLE: begin
                if (i_start) begin
                    cnt_d    = '0;
                    is_div_d = i_is_div;
                    // Divide by zero parks the architectural result directly so FIX passes it through.
                    if (start_dz) begin
                        acc_d    = i_rs;
                        quo_d    = '1;
                        opb_d    = '0;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        dz_d     = 1'b1;
                    end else begin
                        acc_d    = '0;
                        quo_d    = i_is_div ? rs_mag : rt_mag;
                        opb_d    = i_is_div ? rt_mag : rs_mag;
                        neg_lo_d = rs_neg ^ rt_neg;
                        neg_hi_d = rs_neg;
                        dz_d     = 1'b0;
                    end
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[DATA_W:1];
                    quo_d = {mul_sum[0], quo_q[DATA_W-1:1]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q    <= '0;
            quo_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

endmodule

// File: rtl/alu_muldiv_control.sv
// EX-stage ALU control decoder with HI/LO registers, mul/div sequencer
// hookup and the stall handshake to the hazard unit.
module alu_muldiv_control
    import arc_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_con_AluOp,
    input  logic [5:0]        i_con_FuncCode,
    input  logic [3:0]        i_con_Other,
    input  logic              i_con_valid,
    input  logic              i_con_flush,
    input  logic [DATA_W-1:0] i_dat_rs,
    input  logic [DATA_W-1:0] i_dat_rt,
    output logic [3:0]        o_con_AluCtrl,
    output logic              o_con_jumpreg,
    output logic              o_con_hilo_sel,
    output logic              o_con_stall,
    output logic              o_con_busy,
    output logic              o_con_divzero,
    output logic [DATA_W-1:0] o_dat_hilo
);

    alu_ctrl_e         alu_ctrl;
    logic              is_rtype, is_mfhi, is_mflo, is_mthi, is_mtlo, is_muldiv;
    logic              hilo_instr, stall, start, is_div, is_signed;
    logic              core_busy, core_done, core_divzero;
    logic [DATA_W-1:0] core_hi, core_lo;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

    assign is_rtype   = (i_con_AluOp == ALUOP_RTYPE);
    assign is_mfhi    = is_rtype && (i_con_FuncCode == FUNCT_MFHI);
    assign is_mflo    = is_rtype && (i_con_FuncCode == FUNCT_MFLO);
    assign is_mthi    = is_rtype && (i_con_FuncCode == FUNCT_MTHI);
    assign is_mtlo    = is_rtype && (i_con_FuncCode == FUNCT_MTLO);
    assign is_muldiv  = is_rtype && (i_con_FuncCode >= FUNCT_MULT) && (i_con_FuncCode <= FUNCT_DIVU);
    assign is_div     = (i_con_FuncCode == FUNCT_DIV) || (i_con_FuncCode == FUNCT_DIVU);
    assign is_signed  = (i_con_FuncCode == FUNCT_MULT) || (i_con_FuncCode == FUNCT_DIV);
    assign hilo_instr = i_con_valid && (is_mfhi || is_mflo || is_mthi || is_mtlo || is_muldiv);

    // FIX is a busy state, so busy alone covers "busy or finishing".
    assign stall = hilo_instr && core_busy;
    assign start = i_con_valid && is_muldiv && !stall && !i_con_flush;

    always_comb begin
        alu_ctrl       = ALU_INVALID;
        o_con_jumpreg  = 1'b0;
        o_con_hilo_sel = 1'b0;
        unique case (i_con_AluOp)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (i_con_FuncCode)
                    FUNCT_SLL:              alu_ctrl = ALU_SLL;
                    FUNCT_SRL:              alu_ctrl = ALU_SRL;
                    FUNCT_SRA:              alu_ctrl = ALU_SRA;
                    FUNCT_JR, FUNCT_JALR: begin
                        alu_ctrl      = ALU_JR;
                        o_con_jumpreg = 1'b1;
                    end
                    FUNCT_MFHI, FUNCT_MFLO: begin
                        alu_ctrl       = ALU_HILO;
                        o_con_hilo_sel = 1'b1;
                    end
                    FUNCT_ADD, FUNCT_ADDU:  alu_ctrl = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU:  alu_ctrl = ALU_SUB;
                    FUNCT_AND:              alu_ctrl = ALU_AND;
                    FUNCT_OR:               alu_ctrl = ALU_OR;
                    FUNCT_XOR:              alu_ctrl = ALU_XOR;
                    FUNCT_NOR:              alu_ctrl = ALU_NOR;
                    FUNCT_SLT:              alu_ctrl = ALU_SLT;
                    FUNCT_SLTU:             alu_ctrl = ALU_SLTU;
                    default:                alu_ctrl = ALU_INVALID;
                endcase
            end
            ALUOP_ITYPE: begin
                case (i_con_Other)
                    OTHER_ADDI:  alu_ctrl = ALU_ADD;
                    OTHER_ANDI:  alu_ctrl = ALU_AND;
                    OTHER_ORI:   alu_ctrl = ALU_OR;
                    OTHER_XORI:  alu_ctrl = ALU_XOR;
                    OTHER_LUI:   alu_ctrl = ALU_LUI;
                    OTHER_BNE:   alu_ctrl = ALU_BNE;
                    OTHER_SLTI:  alu_ctrl = ALU_SLT;
                    OTHER_SLTIU: alu_ctrl = ALU_SLTU;
                    default:     alu_ctrl = ALU_INVALID;
                endcase
            end
            default: alu_ctrl = ALU_INVALID;
        endcase
    end

    // A finishing sequencer result and a move-to can never collide: move-to stalls while busy.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (core_done) begin
            hi_d = core_hi;
            lo_d = core_lo;
        end else if (hilo_instr && !stall) begin
            if (is_mthi) hi_d = i_dat_rs;
            if (is_mtlo) lo_d = i_dat_rs;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    muldiv_core #(.DATA_W(DATA_W)) u_core (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (start),
        .i_flush     (i_con_flush),
        .i_is_div    (is_div),
        .i_is_signed (is_signed),
        .i_rs        (i_dat_rs),
        .i_rt        (i_dat_rt),
        .o_busy      (core_busy),
        .o_done      (core_done),
        .o_divzero   (core_divzero),
        .o_hi        (core_hi),
        .o_lo        (core_lo)
    );

    assign o_con_AluCtrl = alu_ctrl;
    assign o_con_stall   = stall;
    assign o_con_busy    = core_busy;
    assign o_con_divzero = core_divzero;
    assign o_dat_hilo    = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

endmodule
